// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-input round-robin stream mux into one registered output, tagged with source channel.
// Latency: 1 cycle from input accept to o_valid/o_data; one word per cycle sustained.
// Backpressure: o_ready low with o_valid high holds the output and drops all i_ready (o_ready -> i_ready is combinational).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   i_valid/i_ready   per-channel handshake, bit k is channel k; i_ready is one-hot or zero
//   i_data            packed channel data, channel k at [k*W +: W]
//   o_valid/o_ready   output handshake
//   o_data, o_ch      registered output word and its source channel
//   i_force, i_sel    only with STREAM_MUX_FORCE_SEL_EN: grant i_sel alone, bypassing round-robin
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   i_valid,
    input  logic [N_CH*W-1:0] i_data,
    output logic [N_CH-1:0]   i_ready,
    output logic              o_valid,
    output logic [W-1:0]      o_data,
    output logic [CW-1:0]     o_ch,
    input  logic              o_ready
`ifdef STREAM_MUX_FORCE_SEL_EN
    ,
    input  logic              i_force,
    input  logic [CW-1:0]     i_sel
`endif
);

    logic [CW-1:0] ptr;        // highest-priority channel for the next grant
    logic          load;       // output register may take a new word this cycle
    logic          gnt_vld;
    logic [CW-1:0] gnt_idx;
    logic [CW:0]   cand;       // one extra bit so ptr+i can be wrapped without overflow
    logic [W-1:0]  gnt_dat;
    logic [CW-1:0] ptr_nxt;
    logic          xfer;

    assign load = !o_valid || o_ready;

    // Scan from ptr upward with wrap; first valid channel wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, ptr} + (CW+1)'(i);
            if (cand >= (CW+1)'(N_CH)) begin
                cand = cand - (CW+1)'(N_CH);
            end
            if (!gnt_vld && i_valid[cand[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
`ifdef STREAM_MUX_FORCE_SEL_EN
        // Forced selection replaces the scan entirely; an idle or
        // out-of-range selection means no grant at all.
        if (i_force) begin
            gnt_vld = 1'b0;
            gnt_idx = '0;
            if ({1'b0, i_sel} < (CW+1)'(N_CH)) begin
                if (i_valid[i_sel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = i_sel;
                end
            end
        end
`endif
    end

    // Ready goes only to the granted channel, so it never depends on
    // other channels' valid once the grant is settled.
    always_comb begin
        i_ready = '0;
        if (!rst && load && gnt_vld) begin
            i_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_idx == CW'(k)) begin
                gnt_dat = i_data[k*W +: W];
            end
        end
    end

    assign ptr_nxt = (gnt_idx == CW'(N_CH-1)) ? '0 : gnt_idx + CW'(1);
    assign xfer    = !rst && load && gnt_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            // Covers both an empty register and drain-and-reload on one edge.
            o_valid <= 1'b1;
            o_data  <= gnt_dat;
            o_ch    <= gnt_idx;
            ptr     <= ptr_nxt;
        end else if (o_ready) begin
            // Drained with nothing to replace it; data/ch keep last value.
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr with N_CH=4, W=8.
// Latency: expected words are pushed when an input transfer is predicted, compared while held on the output.
// Backpressure: o_ready is driven directly by directed and random phases.
module tb_stream_mux_rr;

    localparam int N_CH = 4;
    localparam int W    = 8;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   i_valid;
    logic [N_CH*W-1:0] i_data;
    logic [N_CH-1:0]   i_ready;
    logic              o_valid;
    logic [W-1:0]      o_data;
    logic [CW-1:0]     o_ch;
    logic              o_ready;
`ifdef STREAM_MUX_FORCE_SEL_EN
    logic              i_force;
    logic [CW-1:0]     i_sel;
`endif

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_ready (o_ready)
`ifdef STREAM_MUX_FORCE_SEL_EN
        ,
        .i_force (i_force),
        .i_sel   (i_sel)
`endif
    );

    typedef struct {
        logic [CW-1:0] ch;
        logic [W-1:0]  dat;
    } word_t;

    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    m_ptr;
    bit    m_ovld;
    word_t m_last;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference arbiter: -1 means no grant.
    function automatic int model_gnt();
`ifdef STREAM_MUX_FORCE_SEL_EN
        if (i_force) begin
            if (int'(i_sel) < N_CH && i_valid[i_sel]) return int'(i_sel);
            return -1;
        end
`endif
        for (int i = 0; i < N_CH; i++) begin
            int k;
            k = (m_ptr + i) % N_CH;
            if (i_valid[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check combinational and registered outputs at negedge,
    // then advance the model at the posedge. Returns 1 time unit after it.
    task automatic cycle();
        int              g;
        bit              ld;
        logic [N_CH-1:0] exp_rdy;
        @(negedge clk);
        g       = model_gnt();
        ld      = !m_ovld || o_ready;
        exp_rdy = '0;
        if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("i_ready", 32'(i_ready), 32'(exp_rdy));
        chk("o_valid", 32'(o_valid), 32'(m_ovld));
        if (m_ovld) begin
            if (sb.size() == 0) begin
                chk("sb_size", 32'(sb.size()), 1);
            end else begin
                chk("o_data", 32'(o_data), 32'(sb[0].dat));
                chk("o_ch", 32'(o_ch), 32'(sb[0].ch));
            end
        end else begin
            chk("o_data_hold", 32'(o_data), 32'(m_last.dat));
            chk("o_ch_hold", 32'(o_ch), 32'(m_last.ch));
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_ovld = 1'b0;
            m_ptr  = 0;
            m_last = '{ch: '0, dat: '0};
        end else begin
            if (m_ovld && o_ready && sb.size() > 0) void'(sb.pop_front());
            if (exp_rdy != '0) begin
                word_t w;
                w.ch  = CW'(g);
                w.dat = i_data[g*W +: W];
                sb.push_back(w);
                m_last = w;
                m_ovld = 1'b1;
                m_ptr  = (g + 1) % N_CH;
            end else if (m_ovld && o_ready) begin
                m_ovld = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        int sp[3];
        sp = '{3, 1, 3};
        rst     = 1'b1;
        i_valid = '1;
        i_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        o_ready = 1'b1;
`ifdef STREAM_MUX_FORCE_SEL_EN
        i_force = 1'b0;
        i_sel   = '0;
`endif
        m_ptr  = 0;
        m_ovld = 1'b0;
        m_last = '{ch: '0, dat: '0};
        @(posedge clk);
        #1;

        // Reset held with every channel requesting
        repeat (2) cycle();
        chk("rst_o_data", 32'(o_data), 32'h0);
        chk("rst_o_ch", 32'(o_ch), 32'h0);

        // Release: channel 0 wins first, then strict rotation
        rst = 1'b0;
        #1;
        chk("first_gnt", 32'(i_ready), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rr_ch", 32'(o_ch), 32'(i % 4));
            chk("rr_dat", 32'(o_data), 32'(8'hA0 + i % 4));
        end

        // Bring ptr to 2, then only ch3 and ch1 request
        i_valid = 4'b0010;
        cycle();
        i_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("sparse_ch", 32'(o_ch), 32'(sp[i]));
        end

        // Backpressure on a held 5C word
        i_data[7:0] = 8'h5C;
        i_valid     = 4'b0001;
        cycle();
        chk("bp_load", 32'(o_data), 32'h5C);
        o_ready = 1'b0;
        i_valid = '1;
        repeat (3) begin
            cycle();
            chk("bp_hold", 32'(o_data), 32'h5C);
            chk("bp_rdy", 32'(i_ready), 32'h0);
        end
        o_ready = 1'b1;
        cycle();
        chk("bp_resume_vld", 32'(o_valid), 32'h1);
        chk("bp_resume_ch", 32'(o_ch), 32'h1);

        // Single word then drain
        i_valid = 4'b0100;
        cycle();
        chk("drain_vld1", 32'(o_valid), 32'h1);
        i_valid = '0;
        cycle();
        chk("drain_vld0", 32'(o_valid), 32'h0);
        chk("drain_dat", 32'(o_data), 32'hA2);
        cycle();

`ifdef STREAM_MUX_FORCE_SEL_EN
        i_force = 1'b1;
        i_sel   = 2'd2;
        i_valid = '1;
        repeat (4) begin
            cycle();
            chk("force_ch", 32'(o_ch), 32'h2);
        end
        i_valid = 4'b1011;
        cycle();
        chk("force_none", 32'(o_valid), 32'h0);
        i_force = 1'b0;
`endif

        // Random traffic with occasional reset
        repeat (400) begin
            rst     = ($urandom_range(0, 49) == 0);
            i_valid = N_CH'($urandom);
            i_data  = $urandom;
            o_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_FORCE_SEL_EN
            i_force = ($urandom_range(0, 7) == 0);
            i_sel   = CW'($urandom);
`endif
            cycle();
        end
        rst     = 1'b0;
        i_valid = '0;
        o_ready = 1'b1;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
